seg7_capture_decoder: RTL and testbench
=======================================

Name: seg7_capture_decoder

Overview:
- Receive end of the seven-segment display interface: samples an active-low 7-segment bus and a one-hot digit-select strobe from a multiplexed display driver.
- Filters glitches with a stability counter, inverse-decodes each settled pattern back to a 4-bit hex nibble, and assembles a NUM_DIGITS-nibble word.
- Presents the word on a valid/ready handshake for loopback checking of display drivers and for reading legacy display-only peripherals.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before acceptance (>=2).
- CNT_W, 4, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- HEX_IN  in  7  segment bus, active-low, bit0=a … bit6=g.
- DIG_SEL  in  NUM_DIGITS  active-high one-hot digit strobe.
- DATA_OUT  out  4*NUM_DIGITS  assembled word; digit i in bits [4i+3:4i].
- BLANK_OUT  out  NUM_DIGITS  bit i set = digit i was blank (its nibble reads 0).
- OUT_VALID  out  1  word available.
- OUT_READY  in  1  consumer accepts the word.
- ERR_PATTERN  out  1  one-cycle pulse when a stable pattern is illegal.

Behaviour:
- Reset values: DATA_OUT=0, BLANK_OUT=0, OUT_VALID=0, ERR_PATTERN=0, captured mask=0, counter=0, prev regs=all ones / 0, FSM=COLLECT.
- Legal active-high patterns {g..a}, nibble 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,67,77,7C,39,5E,79,71.
- Bus value = bitwise NOT of the active-high pattern.
- Blank = bus 7F (all segments off).
- Stability filter:
  - Each edge compares HEX_IN/DIG_SEL with the prev regs.
  - Any difference: counter=0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - Accept fires on the edge where the counter goes STABLE_CYCLES-2 → STABLE_CYCLES-1. That is the STABLE_CYCLES-th consecutive identical sample.
  - Accept fires exactly once per stable interval.
- Accept qualification: DIG_SEL zero or multi-hot → no accept, no error.
- On accept for digit i:
  - Legal pattern: digit i nibble register = decoded value, blank bit i=0, mask bit i=1.
  - Blank: nibble=0, blank bit i=1, mask bit i=1.
  - Illegal: ERR_PATTERN pulses on the next cycle; registers and mask unchanged.
- FSM COLLECT:
  - When the mask is all ones (sampled at an edge), DATA_OUT/BLANK_OUT load from the digit registers, mask clears, OUT_VALID=1, → PRESENT.
  - OUT_VALID rises one edge after the completing accept.
- FSM PRESENT:
  - DATA_OUT/BLANK_OUT held stable.
  - Capture into the digit registers and mask continues.
  - OUT_VALID & OUT_READY at an edge → OUT_VALID=0, → COLLECT.
  - If the mask is already full at that point, the next word is presented one cycle later (one idle cycle between words).
- Recapture of an already-masked digit overwrites its register; the last value wins.
- Reset mid-operation: all state is cleared immediately and asynchronously. The partial word is discarded and OUT_VALID drops without a handshake.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry legal segment-pattern constant table.
  - SEG_BLANK constant.
  - FSM state enum {COLLECT, PRESENT}.
- The forward hex-to-segment decoder consumes the same table.
- One natural sub-module: seg7_inverse_lut.
  - Combinational 7-bit pattern → {legal, blank, nibble[3:0]}.
  - Reused by other display-checking blocks.

Test Plan:
- Basic word: digits 0..3 each show 1,2,3,4 (bus 79,24,30,19) for 8 cycles each → DATA_OUT=0x4321, BLANK_OUT=0000, OUT_VALID rises 1 cycle after the 4th accept.
- Glitch rejection: digit0 bus 40 for 5 cycles, then 79 for 8 cycles → nibble0=1, only one accept, no capture of 0.
- Illegal and blank: digit2 bus 00 (all segments on = 8, legal) → nibble 8; digit1 bus 7E held 8 cycles → ERR_PATTERN one pulse, mask bit1 stays 0; digit1 bus 7F → BLANK_OUT[1]=1, nibble 0.
- Backpressure: OUT_READY=0 while the second word completes → DATA_OUT holds the first word. Raise OUT_READY one cycle → OUT_VALID low one cycle, then the second word is presented.
- Multi-hot DIG_SEL=0011 with bus 40 for 20 cycles → no accept, no ERR_PATTERN, OUT_VALID stays 0.
- Reset asserted mid-collection after 3 digits and again while OUT_VALID=1 → all outputs 0 immediately; a fresh 4-digit sequence is required for the next word.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: legal pattern table, blank code, capture FSM states.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Active-high {g..a} patterns for nibbles 0..F; the bus carries the inverse.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Bus value with every segment off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } cap_state_e;

  function automatic logic [SEG_W-1:0] hex_to_seg_bus(input logic [3:0] nibble);
    return ~SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_inverse_lut.sv
// Combinational inverse decode of an active-low segment bus to {legal, blank, nibble}.
module seg7_inverse_lut
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_bus_i,
  output logic             legal_o,
  output logic             blank_o,
  output logic [3:0]       nibble_o
);

  always_comb begin
    // NOTE: every output gets a default before the search loop so no latch is inferred.
    legal_o  = 1'b0;
    nibble_o = 4'h0;
    blank_o  = (seg_bus_i == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg_bus_i == ~SEG_TABLE[i]) begin
        legal_o  = 1'b1;
        nibble_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a multiplexed active-low 7-segment display, filters glitches and
// presents the assembled hex word on a valid/ready handshake.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    Reset,
  input  logic [SEG_W-1:0]        HEX_IN,
  input  logic [NUM_DIGITS-1:0]   DIG_SEL,
  output logic [4*NUM_DIGITS-1:0] DATA_OUT,
  output logic [NUM_DIGITS-1:0]   BLANK_OUT,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic                    ERR_PATTERN
);

  logic [SEG_W-1:0]            hex_prev_q;
  logic [NUM_DIGITS-1:0]       sel_prev_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [NUM_DIGITS-1:0][3:0]  nib_q, nib_d;
  logic [NUM_DIGITS-1:0]       blank_q, blank_d;
  logic [NUM_DIGITS-1:0]       mask_q, mask_d;
  logic                        err_q, err_d;

  cap_state_e                  state_q;
  logic [4*NUM_DIGITS-1:0]     data_q;
  logic [NUM_DIGITS-1:0]       blank_out_q;
  logic                        valid_q;

  logic same, accept, sel_onehot, load;
  logic lut_legal, lut_blank;
  logic [3:0] lut_nibble;

  seg7_inverse_lut u_lut (
    .seg_bus_i (HEX_IN),
    .legal_o   (lut_legal),
    .blank_o   (lut_blank),
    .nibble_o  (lut_nibble)
  );

  assign same       = (HEX_IN == hex_prev_q) && (DIG_SEL == sel_prev_q);
  // The counter passes STABLE_CYCLES-2 only once per stable interval.
  assign accept     = same && (cnt_q == CNT_W'(STABLE_CYCLES - 2));
  assign sel_onehot = (DIG_SEL != '0) && ((DIG_SEL & (DIG_SEL - 1'b1)) == '0);
  assign load       = (state_q == COLLECT) && (&mask_q);

  always_comb begin
    nib_d   = nib_q;
    blank_d = blank_q;
    mask_d  = load ? '0 : mask_q;
    err_d   = 1'b0;
    if (accept && sel_onehot) begin
      if (lut_legal || lut_blank) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (DIG_SEL[i]) begin
            nib_d[i]   = lut_blank ? 4'h0 : lut_nibble;
            blank_d[i] = lut_blank;
            mask_d[i]  = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      hex_prev_q <= '1;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      // NOTE: the digit registers are few and feed DATA_OUT, so they get a real reset.
      nib_q      <= '0;
      blank_q    <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      hex_prev_q <= HEX_IN;
      sel_prev_q <= DIG_SEL;
      if (!same) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      nib_q   <= nib_d;
      blank_q <= blank_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q     <= COLLECT;
      data_q      <= '0;
      blank_out_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (load) begin
            data_q      <= nib_q;
            blank_out_q <= blank_q;
            valid_q     <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (OUT_READY) begin
            valid_q <= 1'b0;
            state_q <= COLLECT;
          end
        end
      endcase
    end
  end

  assign DATA_OUT    = data_q;
  assign BLANK_OUT   = blank_out_q;
  assign OUT_VALID   = valid_q;
  assign ERR_PATTERN = err_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Scoreboard bench for seg7_capture_decoder: a run-length display model predicts
// words, OUT_VALID and ERR_PATTERN; a negedge monitor compares against the DUT.
module tb_seg7_capture_decoder;

  localparam int ND = 4;
  localparam int SC = 8;

  localparam bit [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic           clk = 1'b0;
  logic           Reset = 1'b1;
  logic [6:0]     HEX_IN = 7'h7F;
  logic [ND-1:0]  DIG_SEL = '0;
  logic [4*ND-1:0] DATA_OUT;
  logic [ND-1:0]  BLANK_OUT;
  logic           OUT_VALID;
  logic           OUT_READY = 1'b0;
  logic           ERR_PATTERN;

  seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .CNT_W(4)) dut (
    .CLOCK_50    (clk),
    .Reset       (Reset),
    .HEX_IN      (HEX_IN),
    .DIG_SEL     (DIG_SEL),
    .DATA_OUT    (DATA_OUT),
    .BLANK_OUT   (BLANK_OUT),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .ERR_PATTERN (ERR_PATTERN)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
  } word_t;

  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference display model.
  int       m_nib   [ND];
  bit       m_blank [ND];
  bit       m_have  [ND];
  bit       m_present, m_err;
  bit [6:0] last_hex;
  bit [3:0] last_sel;
  int       run;
  bit       exp_valid = 1'b0;
  bit       exp_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 0; m_blank[i] = 0; m_have[i] = 0;
    end
    m_present = 0; m_err = 0;
    last_hex = 7'h7F; last_sel = 4'h0; run = 1;
    exp_q.delete();
  endtask

  // Advance the model by one clock edge seeing these inputs.
  task automatic model_step(input bit [6:0] hex, input bit [3:0] sel, input bit rdy);
    int    dig;
    int    found;
    bit    all_have;
    word_t w;
    all_have = 1;
    for (int i = 0; i < ND; i++) all_have &= m_have[i];
    if (m_present) begin
      if (rdy) m_present = 0;
    end else if (all_have) begin
      w.data = 0; w.blank = 0;
      for (int i = 0; i < ND; i++) begin
        w.data  = w.data | 16'(m_nib[i] << (4 * i));
        w.blank = w.blank | 4'(int'(m_blank[i]) << i);
        m_have[i] = 0;
      end
      exp_q.push_back(w);
      m_present = 1;
    end
    if (hex == last_hex && sel == last_sel) run++;
    else run = 1;
    last_hex = hex; last_sel = sel;
    m_err = 0;
    if (run == SC && $countones(sel) == 1) begin
      dig = 0;
      for (int i = 0; i < ND; i++) if (sel[i]) dig = i;
      found = -1;
      for (int k = 0; k < 16; k++) if (hex == ~PAT[k]) found = k;
      if (hex == 7'h7F) begin
        m_nib[dig] = 0; m_blank[dig] = 1; m_have[dig] = 1;
      end else if (found >= 0) begin
        m_nib[dig] = found; m_blank[dig] = 0; m_have[dig] = 1;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // Called just after a rising edge; drives one cycle of stimulus.
  task automatic drive(input bit [6:0] hex, input bit [3:0] sel, input bit rdy);
    HEX_IN = hex; DIG_SEL = sel; OUT_READY = rdy;
    exp_valid = m_present;
    exp_err   = m_err;
    model_step(hex, sel, rdy);
    @(posedge clk); #1;
  endtask

  // rdy_mode: 0 low, 1 high, 2 random.
  task automatic show(input bit [6:0] hex, input bit [3:0] sel, input int n, input int rdy_mode);
    bit r;
    for (int c = 0; c < n; c++) begin
      r = (rdy_mode == 2) ? ($urandom_range(0, 9) < 7) : (rdy_mode == 1);
      drive(hex, sel, r);
    end
  endtask

  task automatic show_nibble(input int nib, input int dig, input int rdy_mode);
    show(~PAT[nib], 4'(1 << dig), SC, rdy_mode);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_data_out",  DATA_OUT,    0);
    check("rst_blank_out", BLANK_OUT,   0);
    check("rst_out_valid", OUT_VALID,   0);
    check("rst_err",       ERR_PATTERN, 0);
    model_reset();
    exp_valid = 0; exp_err = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    Reset = 1'b0;
  endtask

  // Monitor: outputs are stable at the falling edge; a handshake happens on the next rise.
  initial begin
    forever begin
      @(negedge clk);
      if (!Reset) begin
        check("out_valid",   OUT_VALID,   exp_valid);
        check("err_pattern", ERR_PATTERN, exp_err);
        if (OUT_VALID) begin
          check("queue_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            check("data_out",  DATA_OUT,  exp_q[0].data);
            check("blank_out", BLANK_OUT, exp_q[0].blank);
            if (OUT_READY) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit [6:0] hex;
    bit [3:0] sel;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    Reset = 1'b0;
    show(7'h7F, 4'h0, 3, 1);

    // Basic word 0x4321.
    show(7'h79, 4'b0001, SC, 1);
    show(7'h24, 4'b0010, SC, 1);
    show(7'h30, 4'b0100, SC, 1);
    show(7'h19, 4'b1000, SC, 1);
    show(7'h7F, 4'h0, 4, 1);

    // Glitch rejection: short "0" then settled "1".
    show(7'h40, 4'b0001, 5, 1);
    show(7'h79, 4'b0001, SC, 1);
    show_nibble(5, 1, 1);
    show_nibble(6, 2, 1);
    show_nibble(7, 3, 1);
    show(7'h7F, 4'h0, 4, 1);

    // Illegal and blank patterns.
    show(7'h00, 4'b0100, SC, 1);
    show(7'h7E, 4'b0010, SC, 1);
    show(7'h7F, 4'h0, 3, 1);
    show(7'h7F, 4'b0010, SC, 1);
    show_nibble(10, 0, 1);
    show_nibble(15, 3, 1);
    show(7'h7F, 4'h0, 4, 1);

    // Backpressure: second word completes while the first is held.
    for (int d = 0; d < ND; d++) show_nibble(d + 5, d, 0);
    for (int d = 0; d < ND; d++) show_nibble(d + 9, d, 0);
    show(7'h7F, 4'h0, 3, 0);
    show(7'h7F, 4'h0, 1, 1);
    show(7'h7F, 4'h0, 4, 0);
    show(7'h7F, 4'h0, 3, 1);

    // Multi-hot select never captures.
    show(7'h40, 4'b0011, 20, 1);

    // Reset mid-collection, then while a word is presented.
    for (int d = 0; d < 3; d++) show_nibble(d + 1, d, 1);
    do_reset();
    for (int d = 0; d < ND; d++) show_nibble(12 - d, d, 0);
    for (int k = 0; k < 20 && !OUT_VALID; k++) show(7'h7F, 4'h0, 1, 0);
    check("valid_before_reset", OUT_VALID, 1);
    do_reset();
    for (int d = 0; d < 3; d++) show_nibble(d + 2, d, 1);
    show(7'h7F, 4'h0, 4, 1);
    show_nibble(14, 3, 1);
    show(7'h7F, 4'h0, 4, 1);

    // Randomized display traffic with random backpressure.
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 9))
        7, 8:    hex = 7'h7F;
        9:       hex = 7'($urandom);
        default: hex = ~PAT[$urandom_range(0, 15)];
      endcase
      if ($urandom_range(0, 9) == 9) sel = 4'($urandom);
      else sel = 4'(1 << $urandom_range(0, ND - 1));
      show(hex, sel, $urandom_range(1, 14), 2);
    end

    show(7'h7F, 4'h0, 20, 1);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
